// File: rtl/cordic_pkg.sv
// Shared CORDIC constants and the round/saturate helper used by the output stages.
package cordic_pkg;

  localparam int unsigned GAIN_W         = 48;
  localparam int unsigned GAIN_FRAC_BITS = 46;
  localparam logic [GAIN_W-1:0] CORDIC_GAIN_FX = 48'd42731626441408;

  // Wide enough for any product IN_W + GAIN_W + 1 with IN_W up to 47.
  localparam int unsigned RS_W = 96;
  typedef logic signed [RS_W-1:0] wide_t;

  // Round half toward +inf, arithmetic shift right, then clamp to a signed out_w range.
  function automatic wide_t round_sat(wide_t value, int unsigned shift, int unsigned out_w);
    wide_t r;
    wide_t max_v;
    wide_t min_v;
    if (shift == 0) begin
      r = value;
    end else begin
      r = (value + (wide_t'(1) <<< (shift - 1))) >>> shift;
    end
    max_v = (wide_t'(1) <<< (out_w - 1)) - wide_t'(1);
    min_v = -(wide_t'(1) <<< (out_w - 1));
    if (r > max_v) begin
      r = max_v;
    end else if (r < min_v) begin
      r = min_v;
    end
    return r;
  endfunction

endpackage

// File: rtl/cordic_gain_mul.sv
// Registered signed x unsigned-constant multiply, kept alone so it maps onto a DSP block.
module cordic_gain_mul
  import cordic_pkg::*;
#(
  parameter int unsigned       IN_W    = 20,
  parameter logic [GAIN_W-1:0] GAIN_FX = CORDIC_GAIN_FX
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       en,
  input  logic signed [IN_W-1:0]     a,
  output logic signed [IN_W+GAIN_W:0] p
);

  localparam int unsigned P_W = IN_W + GAIN_W + 1;

  logic signed [P_W-1:0] a_ext;
  logic signed [P_W-1:0] g_ext;
  logic signed [P_W-1:0] p_q;

  // Gain is zero-extended so its MSB is never read as a sign bit.
  assign a_ext = P_W'(a);
  assign g_ext = $signed(P_W'(GAIN_FX));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_q <= '0;
    end else if (en) begin
      p_q <= a_ext * g_ext;
    end
  end

  assign p = p_q;

endmodule

// File: rtl/cordic_gain_comp.sv
// CORDIC output stage: gain compensation of X/Y, round/saturate of X/Y/Z, 3-stage
// valid/ready pipeline with a single global advance enable.
module cordic_gain_comp
  import cordic_pkg::*;
#(
  parameter int unsigned       IN_W    = 20,
  parameter int unsigned       OUT_W   = 18,
  parameter logic [GAIN_W-1:0] GAIN_FX = CORDIC_GAIN_FX,
  parameter bit                GAIN_EN = 1'b1
) (
  input  logic                    CLK,
  input  logic                    NGRST,
  input  logic                    din_valid,
  output logic                    din_ready,
  input  logic signed [IN_W-1:0]  x_in,
  input  logic signed [IN_W-1:0]  y_in,
  input  logic signed [IN_W-1:0]  z_in,
  output logic                    dout_valid,
  input  logic                    dout_ready,
  output logic signed [OUT_W-1:0] x_out,
  output logic signed [OUT_W-1:0] y_out,
  output logic signed [OUT_W-1:0] z_out
);

  localparam int unsigned P_W   = IN_W + GAIN_W + 1;
  localparam int unsigned SH_Z  = IN_W - OUT_W;
  localparam int unsigned SH_XY = GAIN_EN ? GAIN_FRAC_BITS + SH_Z : SH_Z;

  logic adv, en1, en2, en3;
  logic v1_q, v2_q, v3_q;
  logic signed [IN_W-1:0]  x1_q, y1_q, z1_q, z2_q;
  logic signed [P_W-1:0]   x2, y2;
  logic signed [OUT_W-1:0] x3_d, y3_d, z3_d;
  logic signed [OUT_W-1:0] x3_q, y3_q, z3_q;

  assign adv = !v3_q || dout_ready;
  assign en1 = adv && din_valid;
  assign en2 = adv && v1_q;
  assign en3 = adv && v2_q;

  always_ff @(posedge CLK or negedge NGRST) begin
    if (!NGRST) begin
      v1_q <= 1'b0;
      v2_q <= 1'b0;
      v3_q <= 1'b0;
    end else if (adv) begin
      v1_q <= din_valid;
      v2_q <= v1_q;
      v3_q <= v2_q;
    end
  end

  always_ff @(posedge CLK or negedge NGRST) begin
    if (!NGRST) begin
      x1_q <= '0;
      y1_q <= '0;
      z1_q <= '0;
    end else if (en1) begin
      x1_q <= x_in;
      y1_q <= y_in;
      z1_q <= z_in;
    end
  end

  always_ff @(posedge CLK or negedge NGRST) begin
    if (!NGRST) begin
      z2_q <= '0;
    end else if (en2) begin
      z2_q <= z1_q;
    end
  end

  if (GAIN_EN) begin : g_mul
    cordic_gain_mul #(
      .IN_W   (IN_W),
      .GAIN_FX(GAIN_FX)
    ) u_mul_x (
      .clk  (CLK),
      .rst_n(NGRST),
      .en   (en2),
      .a    (x1_q),
      .p    (x2)
    );

    cordic_gain_mul #(
      .IN_W   (IN_W),
      .GAIN_FX(GAIN_FX)
    ) u_mul_y (
      .clk  (CLK),
      .rst_n(NGRST),
      .en   (en2),
      .a    (y1_q),
      .p    (y2)
    );
  end else begin : g_byp
    logic signed [P_W-1:0] x2_q, y2_q;

    always_ff @(posedge CLK or negedge NGRST) begin
      if (!NGRST) begin
        x2_q <= '0;
        y2_q <= '0;
      end else if (en2) begin
        x2_q <= P_W'(x1_q);
        y2_q <= P_W'(y1_q);
      end
    end

    assign x2 = x2_q;
    assign y2 = y2_q;
  end

  always_comb begin
    x3_d = OUT_W'(round_sat(wide_t'(x2), SH_XY, OUT_W));
    y3_d = OUT_W'(round_sat(wide_t'(y2), SH_XY, OUT_W));
    z3_d = OUT_W'(round_sat(wide_t'(z2_q), SH_Z, OUT_W));
  end

  always_ff @(posedge CLK or negedge NGRST) begin
    if (!NGRST) begin
      x3_q <= '0;
      y3_q <= '0;
      z3_q <= '0;
    end else if (en3) begin
      x3_q <= x3_d;
      y3_q <= y3_d;
      z3_q <= z3_d;
    end
  end

  assign din_ready  = adv;
  assign dout_valid = v3_q;
  assign x_out      = x3_q;
  assign y_out      = y3_q;
  assign z_out      = z3_q;

endmodule

// File: tb/tb_cordic_gain_comp.sv
// Bench for cordic_gain_comp: default, gain-2.0 and bypass instances share one stimulus
// stream and are scored against an exact-arithmetic model through a FIFO scoreboard.
module tb_cordic_gain_comp;

  localparam int IN_W  = 20;
  localparam int OUT_W = 18;
  localparam logic [47:0] GAIN_DEF = 48'd42731626441408;
  localparam logic [47:0] GAIN_TWO = 48'h8000_0000_0000;
  localparam int SH_G = 46 + (IN_W - OUT_W);
  localparam int SH_P = IN_W - OUT_W;

  typedef struct {
    longint x, y, z, xg, yg, xb, yb;
    int     acc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic din_valid, dout_ready;
  logic signed [IN_W-1:0] x_in, y_in, z_in;
  logic din_ready, dout_valid;
  logic signed [OUT_W-1:0] x_out, y_out, z_out;
  logic din_ready_g, dout_valid_g;
  logic signed [OUT_W-1:0] x_out_g, y_out_g, z_out_g;
  logic din_ready_b, dout_valid_b;
  logic signed [OUT_W-1:0] x_out_b, y_out_b, z_out_b;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  bit lat_chk = 1'b0;
  exp_t q[$];
  logic held = 1'b0;
  logic signed [OUT_W-1:0] hx, hy, hz;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  cordic_gain_comp dut (
    .CLK(clk), .NGRST(rst_n), .din_valid(din_valid), .din_ready(din_ready),
    .x_in(x_in), .y_in(y_in), .z_in(z_in), .dout_valid(dout_valid),
    .dout_ready(dout_ready), .x_out(x_out), .y_out(y_out), .z_out(z_out)
  );

  cordic_gain_comp #(.GAIN_FX(GAIN_TWO)) dut_g (
    .CLK(clk), .NGRST(rst_n), .din_valid(din_valid), .din_ready(din_ready_g),
    .x_in(x_in), .y_in(y_in), .z_in(z_in), .dout_valid(dout_valid_g),
    .dout_ready(dout_ready), .x_out(x_out_g), .y_out(y_out_g), .z_out(z_out_g)
  );

  cordic_gain_comp #(.GAIN_EN(1'b0)) dut_b (
    .CLK(clk), .NGRST(rst_n), .din_valid(din_valid), .din_ready(din_ready_b),
    .x_in(x_in), .y_in(y_in), .z_in(z_in), .dout_valid(dout_valid_b),
    .dout_ready(dout_ready), .x_out(x_out_b), .y_out(y_out_b), .z_out(z_out_b)
  );

  task automatic check(input string tag, input longint got, input longint exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Exact integer reference: floor((v + d/2) / d) with d = 2^s, then clamp.
  function automatic longint fmt(input logic signed [127:0] v, input int s);
    logic signed [127:0] d, num, r, maxv, minv;
    if (s == 0) begin
      r = v;
    end else begin
      d   = 128'sd1 <<< s;
      num = v + d / 2;
      r   = num / d;
      if ((num % d) != 0 && num < 0) r = r - 1;
    end
    maxv = (128'sd1 <<< (OUT_W - 1)) - 1;
    minv = -(128'sd1 <<< (OUT_W - 1));
    if (r > maxv) r = maxv;
    if (r < minv) r = minv;
    return longint'(r);
  endfunction

  function automatic logic signed [127:0] gmul(input longint v, input logic [47:0] g);
    logic signed [127:0] a, b;
    a = v;
    b = {80'd0, g};
    return a * b;
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      held <= 1'b0;
    end else begin
      check("din_ready", din_ready, !dout_valid || dout_ready);
      check("din_ready_g", din_ready_g, !dout_valid_g || dout_ready);
      check("din_ready_b", din_ready_b, !dout_valid_b || dout_ready);
      if (held) begin
        check("hold_x", x_out, hx);
        check("hold_y", y_out, hy);
        check("hold_z", z_out, hz);
        check("hold_valid", dout_valid, 1);
      end
      if (din_valid && din_ready) begin
        exp_t e;
        longint xi, yi, zi;
        xi = longint'(x_in);
        yi = longint'(y_in);
        zi = longint'(z_in);
        e.x   = fmt(gmul(xi, GAIN_DEF), SH_G);
        e.y   = fmt(gmul(yi, GAIN_DEF), SH_G);
        e.z   = fmt(zi, SH_P);
        e.xg  = fmt(gmul(xi, GAIN_TWO), SH_G);
        e.yg  = fmt(gmul(yi, GAIN_TWO), SH_G);
        e.xb  = fmt(xi, SH_P);
        e.yb  = fmt(yi, SH_P);
        e.acc = cyc;
        q.push_back(e);
      end
      if (dout_valid && dout_ready) begin
        if (q.size() == 0) begin
          check("spurious_out", 1, 0);
        end else begin
          exp_t e;
          e = q.pop_front();
          check("x_out", x_out, e.x);
          check("y_out", y_out, e.y);
          check("z_out", z_out, e.z);
          check("g_valid", dout_valid_g, 1);
          check("x_out_g", x_out_g, e.xg);
          check("y_out_g", y_out_g, e.yg);
          check("z_out_g", z_out_g, e.z);
          check("b_valid", dout_valid_b, 1);
          check("x_out_b", x_out_b, e.xb);
          check("y_out_b", y_out_b, e.yb);
          check("z_out_b", z_out_b, e.z);
          if (lat_chk) check("latency", cyc - e.acc, 3);
        end
      end
      held <= dout_valid && !dout_ready;
      hx   <= x_out;
      hy   <= y_out;
      hz   <= z_out;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input longint x, input longint y, input longint z);
    din_valid = 1'b1;
    x_in = IN_W'(x);
    y_in = IN_W'(y);
    z_in = IN_W'(z);
  endtask

  function automatic longint rnd_val();
    logic signed [IN_W-1:0] v;
    case ($urandom_range(0, 9))
      0:       v = IN_W'(524287);
      1:       v = IN_W'(-524288);
      default: v = IN_W'($urandom);
    endcase
    return longint'(v);
  endfunction

  initial begin
    int k;
    bit acc;
    rst_n = 1'b0;
    din_valid = 1'b0;
    dout_ready = 1'b1;
    x_in = '0;
    y_in = '0;
    z_in = '0;
    #12;
    check("rst_valid", dout_valid, 0);
    check("rst_x", x_out, 0);
    check("rst_y", y_out, 0);
    check("rst_z", z_out, 0);
    check("rst_ready", din_ready, 1);
    step();
    rst_n = 1'b1;
    step();

    // Single sample with directed values
    lat_chk = 1'b1;
    drive(100000, -100000, 1000);
    step();
    din_valid = 1'b0;
    step();
    step();
    check("single_valid", dout_valid, 1);
    check("single_x", x_out, 15181);
    check("single_y", y_out, -15181);
    check("single_z", z_out, 250);
    step();
    check("single_once", dout_valid, 0);
    repeat (3) step();

    // Saturation extremes (Z and gain-2.0 instance)
    drive(524287, -524288, 524287);
    step();
    drive(-524288, 524287, -524288);
    step();
    din_valid = 1'b0;
    step();
    check("zsat_hi", z_out, 131071);
    check("gsat_hi", x_out_g, 131071);
    step();
    check("zsat_lo", z_out, -131072);
    check("gsat_lo", x_out_g, -131072);
    repeat (3) step();

    // Backpressure: 8 samples, dout_ready low for 4 cycles mid-stream
    lat_chk = 1'b0;
    k = 0;
    for (int i = 0; i < 40 && k < 8; i++) begin
      dout_ready = !(i >= 4 && i < 8);
      drive(1000 * (k + 1), -1000 * (k + 1), 10 * k);
      #2;
      acc = din_ready;
      if (i >= 5 && i < 8) check("stall_ready", din_ready, 0);
      step();
      if (acc) k++;
    end
    din_valid = 1'b0;
    dout_ready = 1'b1;
    repeat (6) step();
    check("bp_drained", q.size(), 0);

    // Back-to-back: 16 consecutive samples
    lat_chk = 1'b1;
    for (int i = 0; i < 16; i++) begin
      drive(rnd_val(), rnd_val(), rnd_val());
      step();
    end
    din_valid = 1'b0;
    repeat (5) step();

    // Reset mid-stream
    drive(200000, -200000, 4000);
    step();
    drive(300000, 300000, 8000);
    step();
    drive(-300000, 1000, -8000);
    step();
    din_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("mrst_valid", dout_valid, 0);
    check("mrst_x", x_out, 0);
    check("mrst_y", y_out, 0);
    check("mrst_z", z_out, 0);
    check("mrst_g_x", x_out_g, 0);
    q.delete();
    step();
    step();
    rst_n = 1'b1;
    repeat (6) step();
    check("mrst_no_stale", dout_valid, 0);
    drive(100000, 50000, -1000);
    step();
    din_valid = 1'b0;
    step();
    step();
    check("mrst_new_valid", dout_valid, 1);
    check("mrst_new_z", z_out, -250);
    repeat (3) step();

    // Randomized traffic with random backpressure
    lat_chk = 1'b0;
    for (int i = 0; i < 400; i++) begin
      dout_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 9) < 7) drive(rnd_val(), rnd_val(), rnd_val());
      else din_valid = 1'b0;
      step();
    end
    din_valid = 1'b0;
    dout_ready = 1'b1;
    for (int i = 0; i < 20 && q.size() != 0; i++) step();
    step();
    check("final_drain", q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
